// File: rtl/pipeline_run_monitor.sv
// pipeline_run_monitor: run controller and write-back retirement monitor.
// After a start pulse it counts cycles and retired instructions and ends the
// run on end-PC retirement (after the pipeline drains), on cycle-budget
// exhaustion, or on a hang. done/done_cause are sticky until reset.
// Optional feature macro: MONITOR_PC_RANGE_CHECK_EN builds the retired-PC
// range/alignment checker driving pc_err; otherwise pc_err is tied 0.
//
// state | meaning
// IDLE  | waiting for start; retirements ignored
// RUN   | counting; watching for end PC, budget and hang
// DRAIN | end PC retired; counting while the pipeline empties
// DONE  | run finished; everything frozen until reset
module pipeline_run_monitor #(
    parameter int              PC_W       = 32,
    parameter int              STAGES     = 5,
    parameter logic [PC_W-1:0] TEXT_BASE  = PC_W'(32'h0000_3000),
    parameter int              INST_NUM   = 41,
    parameter logic [PC_W-1:0] END_PC     = TEXT_BASE + PC_W'(4 * (INST_NUM - 1)),
    parameter int              MAX_CYCLES = (INST_NUM + 20) * 5,
    parameter int              HANG_LIMIT = 16,
    parameter int              CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             wb_valid,
    input  logic [PC_W-1:0]  wb_pc,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [PC_W-1:0]  last_pc,
    output logic             busy,
    output logic             done,
    output logic [1:0]       done_cause,
    output logic             pc_err
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] HANG_C  = CNT_W'(HANG_LIMIT);
    localparam logic [CNT_W-1:0] DRAIN_C = CNT_W'(STAGES);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state, state_nxt;
    logic [1:0]       cause_nxt;
    logic [CNT_W-1:0] idle_run, drain_cnt;
    logic [CNT_W-1:0] cyc_inc, ret_inc, idle_inc;
    logic             counting, end_hit, budget_hit, hang_hit;

    // Saturating increments: counters stick at all-ones instead of wrapping.
    assign cyc_inc  = (cycle_cnt == '1)  ? cycle_cnt  : cycle_cnt + ONE;
    assign ret_inc  = (retire_cnt == '1) ? retire_cnt : retire_cnt + ONE;
    assign idle_inc = (idle_run == '1)   ? idle_run   : idle_run + ONE;

    assign counting   = (state == S_RUN) || (state == S_DRAIN);
    assign end_hit    = wb_valid && (wb_pc == END_PC);
    // '>=' lets a budget reached on the END_PC edge still end the run in DRAIN.
    assign budget_hit = (cyc_inc >= MAX_C);
    // A retiring cycle is not silent, so it can never complete a hang.
    assign hang_hit   = !wb_valid && (idle_inc == HANG_C);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state and termination cause selection.
    always_comb begin
        state_nxt = state;
        cause_nxt = done_cause;
        case (state)
            S_IDLE: if (start) state_nxt = S_RUN;
            S_RUN: begin
                if (end_hit) begin
                    state_nxt = S_DRAIN;
                end else if (budget_hit) begin
                    state_nxt = S_DONE;
                    cause_nxt = 2'b10;
                end else if (hang_hit) begin
                    state_nxt = S_DONE;
                    cause_nxt = 2'b11;
                end
            end
            S_DRAIN: begin
                if (budget_hit) begin
                    state_nxt = S_DONE;
                    cause_nxt = 2'b10;
                end else if (drain_cnt == ONE) begin
                    state_nxt = S_DONE;
                    cause_nxt = 2'b01;
                end
            end
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Counters, last PC, drain timer and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
            last_pc    <= '0;
            idle_run   <= '0;
            drain_cnt  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            done_cause <= 2'b00;
        end else begin
            busy       <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
            done       <= (state_nxt == S_DONE);
            done_cause <= cause_nxt;
            if (state == S_IDLE && start) begin
                cycle_cnt  <= '0;
                retire_cnt <= '0;
                last_pc    <= '0;
                idle_run   <= '0;
                drain_cnt  <= '0;
            end else if (counting) begin
                cycle_cnt <= cyc_inc;
                if (wb_valid) begin
                    retire_cnt <= ret_inc;
                    last_pc    <= wb_pc;
                    idle_run   <= '0;
                end else begin
                    idle_run <= idle_inc;
                end
                if (state == S_RUN && end_hit) drain_cnt <= DRAIN_C;
                else if (state == S_DRAIN)     drain_cnt <= drain_cnt - ONE;
            end
        end
    end

`ifdef MONITOR_PC_RANGE_CHECK_EN
    localparam logic [PC_W-1:0] TEXT_END = TEXT_BASE + PC_W'(4 * INST_NUM);

    logic pc_bad;
    assign pc_bad = (wb_pc < TEXT_BASE) || (wb_pc >= TEXT_END) || (wb_pc[1:0] != 2'b00);

    // Sticky flag for any out-of-range or misaligned retirement while monitoring.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                             pc_err <= 1'b0;
        else if (counting && wb_valid && pc_bad) pc_err <= 1'b1;
    end
`else
    assign pc_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_run_monitor.sv
// Testbench for pipeline_run_monitor: stimulus traces are generated up front,
// a trace-level model derives when and why the run ends, and the DUT is
// checked cycle by cycle against it.
module tb_pipeline_run_monitor;
    localparam logic [31:0] TEXT_BASE = 32'h0000_3000;
    localparam logic [31:0] END_PC    = 32'h0000_30A0;
    localparam int          MAXC      = 305;
    localparam int          HANG      = 16;
    localparam int          STG       = 5;
    localparam int          NMAX      = 400;
    localparam int          INF       = 1000000;

    logic        clk = 1'b0;
    logic        rst, start, wb_valid;
    logic [31:0] wb_pc;
    logic [31:0] cycle_cnt, retire_cnt, last_pc;
    logic        busy, done, pc_err;
    logic [1:0]  done_cause;

    int total = 0;
    int bad   = 0;

    logic        v [1:NMAX];
    logic [31:0] p [1:NMAX];
    int          exp_end;
    logic [1:0]  exp_cause;

    pipeline_run_monitor dut (
        .clk(clk), .rst(rst), .start(start), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .last_pc(last_pc),
        .busy(busy), .done(done), .done_cause(done_cause), .pc_err(pc_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic pc_is_bad(input logic [31:0] pc);
        return (pc < TEXT_BASE) || (pc >= TEXT_BASE + 32'd164) || (pc[1:0] != 2'b00);
    endfunction

    task automatic check_zero(input string tag);
        check_val({tag, "_cycle"},  cycle_cnt, 0);
        check_val({tag, "_retire"}, retire_cnt, 0);
        check_val({tag, "_lastpc"}, last_pc, 0);
        check_val({tag, "_busy"},   busy, 0);
        check_val({tag, "_done"},   done, 0);
        check_val({tag, "_cause"},  done_cause, 0);
        check_val({tag, "_pcerr"},  pc_err, 0);
    endtask

    // mode 0 straight, 1 budget, 2 hang, 3 simultaneous, 4 random (dens = % valid)
    task automatic fill(input int mode, input int dens);
        logic [31:0] bad_pc [4];
        int r;
        bad_pc[0] = 32'h0000_2FFC;
        bad_pc[1] = 32'h0000_30A4;
        bad_pc[2] = 32'h0000_3002;
        bad_pc[3] = $urandom;
        for (int j = 1; j <= NMAX; j++) begin
            case (mode)
                0: begin v[j] = (j <= 41); p[j] = (j <= 41) ? TEXT_BASE + 32'(4 * (j - 1)) : $urandom; end
                1: begin v[j] = 1'b1; p[j] = TEXT_BASE; end
                2: begin v[j] = (j <= 3); p[j] = TEXT_BASE + 32'(4 * (j - 1)); end
                3: begin v[j] = 1'b1; p[j] = (j == MAXC) ? END_PC : TEXT_BASE + 32'(4 * (j % 40)); end
                default: begin
                    v[j] = ($urandom_range(99) < dens);
                    r = $urandom_range(99);
                    if (r < 2)      p[j] = END_PC;
                    else if (r < 6) p[j] = bad_pc[$urandom_range(3)];
                    else            p[j] = TEXT_BASE + 32'(4 * $urandom_range(39));
                end
            endcase
        end
    endtask

    // Run-end derivation from the whole trace: first hang point, first END_PC
    // retirement, and the budget; END_PC then drains STAGES cycles unless the
    // budget is reached first (budget wins a tie during drain).
    task automatic compute_model();
        int h, e, streak, bud;
        h = INF; e = INF; streak = 0;
        for (int j = 1; j <= NMAX; j++) begin
            streak = v[j] ? 0 : streak + 1;
            if (h == INF && streak == HANG) h = j;
            if (e == INF && v[j] && p[j] == END_PC) e = j;
        end
        if (h < e && h < MAXC) begin
            exp_end = h; exp_cause = 2'b11;
        end else if (e <= MAXC) begin
            bud = (MAXC > e + 1) ? MAXC : e + 1;
            if (bud <= e + STG) begin exp_end = bud;     exp_cause = 2'b10; end
            else                begin exp_end = e + STG; exp_cause = 2'b01; end
        end else begin
            exp_end = MAXC; exp_cause = 2'b10;
        end
    endtask

    task automatic run_scn(input string tag, input bit do_reset);
        int          ret;
        logic [31:0] lpc;
        logic        pe;
        compute_model();
        if (do_reset) begin
            rst = 1'b0; start = 1'b0; wb_valid = 1'b0; wb_pc = '0;
            @(negedge clk);
            check_zero({tag, "_rst"});
            rst = 1'b1;
        end
        start    = 1'b1;
        wb_valid = 1'($urandom_range(1));
        wb_pc    = $urandom_range(1) ? END_PC : 32'hDEAD_BEEF;
        @(negedge clk);
        check_val({tag, "_start_busy"},  busy, 1);
        check_val({tag, "_start_cycle"}, cycle_cnt, 0);
        check_val({tag, "_start_ret"},   retire_cnt, 0);
        ret = 0; lpc = '0; pe = 1'b0;
        for (int j = 1; j <= exp_end + 3; j++) begin
            wb_valid = v[j];
            wb_pc    = p[j];
            start    = (j > exp_end) ? 1'($urandom_range(1)) : 1'b0;
            @(negedge clk);
            if (j <= exp_end && v[j]) begin
                ret++;
                lpc = p[j];
                if (pc_is_bad(p[j])) pe = 1'b1;
            end
            check_val({tag, "_cycle"}, cycle_cnt, (j < exp_end) ? j : exp_end);
            check_val({tag, "_done"},  done, (j >= exp_end));
            check_val({tag, "_busy"},  busy, (j < exp_end));
            check_val({tag, "_cause"}, done_cause, (j >= exp_end) ? exp_cause : 2'b00);
`ifdef MONITOR_PC_RANGE_CHECK_EN
            check_val({tag, "_pcerr"}, pc_err, pe);
`else
            check_val({tag, "_pcerr"}, pc_err, 0);
`endif
        end
        check_val({tag, "_retire"}, retire_cnt, ret);
        check_val({tag, "_lastpc"}, last_pc, lpc);
        check_val({tag, "_endcause"}, done_cause, exp_cause);
        start = 1'b0; wb_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; wb_valid = 1'b0; wb_pc = '0;
        repeat (2) @(negedge clk);

        fill(0, 0);
        run_scn("straight", 1);
        check_val("straight_cause01", done_cause, 2'b01);
        check_val("straight_ret41", retire_cnt, 41);
        check_val("straight_last", last_pc, END_PC);

        fill(1, 0);
        run_scn("budget", 1);
        check_val("budget_cycle305", cycle_cnt, 305);

        fill(2, 0);
        run_scn("hang", 1);
        check_val("hang_ret3", retire_cnt, 3);

        fill(3, 0);
        run_scn("simul", 1);
        check_val("simul_cause10", done_cause, 2'b10);

        // Asynchronous reset in the middle of a run, then a fresh start.
        fill(1, 0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 1; j <= 100; j++) begin
            wb_valid = 1'b1; wb_pc = TEXT_BASE;
            @(negedge clk);
        end
        check_val("midrst_pre_cycle", cycle_cnt, 100);
        #2 rst = 1'b0;
        #1 check_zero("midrst");
        @(negedge clk);
        check_zero("midrst_held");
        rst = 1'b1; wb_valid = 1'b0;
        fill(0, 0);
        run_scn("after_rst", 0);

        fill(0, 0);
        p[1] = 32'h0000_2FFC;
        run_scn("range", 1);

        for (int i = 0; i < 10; i++) begin
            fill(4, (i < 5) ? 85 : 25);
            run_scn("rand", 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipeline_run_monitor.md
# pipeline_run_monitor

Cycle-accurate run controller and retirement monitor for the pipelined CPU simulation environment. It replaces a fixed "stop after N half-periods" scheme with a parametrised block that counts cycles and retired instructions and detects program end, cycle-budget exhaustion or pipeline hang. It then raises a sticky `done` with a cause code. It sits beside the CPU in the bench, observes the write-back stage, and is written as synthesizable RTL.

## Interface
- `PC_W`, 32: PC width.
- `STAGES`, 5: pipeline depth; sets the drain length after the end PC retires.
- `TEXT_BASE`, 32'h0000_3000: first instruction address.
- `INST_NUM`, 41: program length in words.
- `END_PC`, TEXT_BASE+4*(INST_NUM-1): address whose retirement ends the run.
- `MAX_CYCLES`, (INST_NUM+20)*5: cycle budget.
- `HANG_LIMIT`, 16: number of consecutive non-retiring cycles that count as a hang.
- `CNT_W`, 32: counter width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse that begins monitoring.
- `wb_valid` in 1: an instruction retires this cycle.
- `wb_pc` in PC_W: PC of the retiring instruction.
- `cycle_cnt` out CNT_W: cycles spent in RUN and DRAIN.
- `retire_cnt` out CNT_W: number of retired instructions.
- `last_pc` out PC_W: PC of the most recent retirement.
- `busy` out 1: high in RUN or DRAIN.
- `done` out 1: sticky end-of-run flag.
- `done_cause` out 2: 00 none, 01 end PC, 10 cycle budget, 11 hang.
- `pc_err` out 1: sticky; present only with the configuration macro, otherwise tied 0.

## Operation
- **States:** IDLE, RUN, DRAIN, DONE.
- **IDLE:**
  - On `start`, go to RUN.
  - Counters were cleared on reset; a `start` pulse while in IDLE also clears them.
  - `wb_valid` is ignored.
- **RUN:**
  - `cycle_cnt` increments by 1 every cycle.
  - When `wb_valid` is high: `retire_cnt` increments and `last_pc` loads `wb_pc`.
  - `idle_run` counts consecutive cycles with `wb_valid` low and clears on any retirement.
  - Exit priority, evaluated each cycle:
    1. `wb_valid && wb_pc==END_PC`: go to DRAIN and load the drain counter with STAGES.
    2. `cycle_cnt+1 == MAX_CYCLES`: go to DONE, cause 10.
    3. `idle_run+1 == HANG_LIMIT`: go to DONE, cause 11.
- **DRAIN:**
  - Counting continues as in RUN.
  - The drain counter decrements each cycle; at 1, go to DONE with cause 01.
  - The cycle budget still applies: reaching it in DRAIN gives cause 10.
  - Hang detection is disabled in DRAIN.
- **DONE:**
  - All counters and `last_pc` freeze.
  - `done`=1 and `busy`=0.
  - `start` is ignored; only reset leaves DONE.
- **Counters:** both saturate at all-ones and never wrap.
- **Widths:** comparisons use CNT_W-bit unsigned values; parameters are truncated to CNT_W.

## Timing
- Reset (asynchronous assert, synchronous release by clock edge): state IDLE, and every output is 0 (`cycle_cnt`, `retire_cnt`, `last_pc`, `busy`, `done`, `done_cause`, `pc_err`).
- `start` sampled at edge k: `busy`=1 after edge k. The first `cycle_cnt` increment happens at edge k+1.
- All outputs are registered. `done`/`done_cause` rise at the same edge that enters DONE, so they are visible one cycle after the triggering condition.
- END_PC retired at edge e: `done`=1 after edge e+STAGES, and `cycle_cnt` has advanced by STAGES.
- When END_PC retirement and cycle-budget exhaustion occur on the same edge, END_PC wins and the run enters DRAIN. The budget can still end the run during DRAIN with cause 10.
- Reset asserted mid-run returns the block to IDLE with all outputs 0 immediately, without waiting for a clock edge.

## Configuration
- **`MONITOR_PC_RANGE_CHECK_EN` defined:** in RUN/DRAIN, a retirement with `wb_pc` outside [TEXT_BASE, TEXT_BASE+4*INST_NUM) or with `wb_pc[1:0]`≠0 sets `pc_err` at the next edge.
  - `pc_err` is sticky until reset.
  - It does not change state or cause.
- **Undefined:** no checker logic is built and `pc_err` is a constant 0.

## Test plan
- **Straight retire:** reset, `start`, then 41 consecutive retirements PC 0x3000..0x30A0 → DRAIN entered at 0x30A0; `done`=1 with cause 01 five cycles later; `retire_cnt`=41; `last_pc`=0x30A0.
- **Budget:** `start` with no END_PC retirement, but a retirement every cycle at 0x3000 → `done` with cause 10 when `cycle_cnt`=305; counters then frozen.
- **Hang:** 3 retirements followed by `wb_valid` held low → cause 11 after 16 silent cycles; `retire_cnt`=3.
- **Simultaneous:** END_PC retired on the same edge the budget expires → DRAIN entered, then `done` with cause 10 on the next edge.
- **Reset mid-run:** after 100 cycles in RUN, pulse `rst` low between clock edges → all outputs 0 immediately; `start` afterwards restarts counting from 0.
- **Range check** (macro defined): retire `wb_pc`=0x2FFC → `pc_err`=1 at the next edge and stays 1; state unaffected. With the macro undefined, `pc_err` stays 0.
